mu_mem_arbiter: RTL and testbench
=================================

MU_MEM_ARBITER -- requirements
Module: mu_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_W, default `CPU_WIDTH (32), meaning data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive LSU grants while IF is pending.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 if_req_valid / if_req_ready  in / out  1 / 1  instruction-fetch request handshake.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_rsp_valid / if_rdata  out / out  1 / DATA_W  fetch response pulse and data.
REQ-009 ls_req_valid / ls_req_ready  in / out  1 / 1  load-store request handshake.
REQ-010 ls_addr, ls_we, ls_wdata, ls_wstrb  in  ADDR_W, 1, DATA_W, DATA_W/8  LSU address, write enable, write data, byte strobes.
REQ-011 ls_rsp_valid / ls_rdata  out / out  1 / DATA_W  LSU response pulse and data (writes included).
REQ-012 mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb  out  1, ADDR_W, 1, DATA_W, DATA_W/8  shared memory request.
REQ-013 mem_gnt  in  1  memory accepts mem_req this cycle.
REQ-014 mem_rvalid / mem_rdata  in / in  1 / DATA_W  memory completion (read data or write ack).
REQ-015 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE and WAIT; at most one memory transaction outstanding.
REQ-017 In IDLE, if_req_ready and ls_req_ready SHALL be combinationally derived so that exactly the arbitration winner sees ready=1; both SHALL be 0 outside IDLE.
REQ-018 Arbitration SHALL give LSU priority, except that IF wins when if_req_valid=1 and starve_cnt==STARVE_MAX.
REQ-019 starve_cnt SHALL increment on each LSU acceptance while if_req_valid=1, SHALL clear on any IF acceptance, and SHALL saturate at STARVE_MAX.
REQ-020 On acceptance (valid&ready in IDLE), the block SHALL latch the owner, address, we, wdata and wstrb, then move to ISSUE the next cycle.
REQ-021 IF requests SHALL be issued with mem_we=0 and mem_wstrb=0.
REQ-022 In ISSUE, mem_req SHALL be 1 with the latched fields held stable; on mem_gnt=1 the FSM SHALL move to WAIT.
REQ-023 In WAIT, on mem_rvalid=1 the FSM SHALL pulse the owner's rsp_valid for exactly one cycle, with rdata registered from mem_rdata (0 for writes), and SHALL return to IDLE in the same transition.
REQ-024 rsp_valid SHALL be registered, so that it is high in the first IDLE cycle; a new request SHALL be acceptable in that same cycle.
REQ-025 Minimum latency SHALL be 3 cycles: accept at N, mem_req at N+1 (gnt at N+1), rvalid at N+2, rsp_valid at N+3.
REQ-026 mem_rvalid outside WAIT SHALL be ignored and SHALL NOT produce any rsp_valid.
REQ-027 mem_gnt outside ISSUE SHALL be ignored.
REQ-028 The non-owner's rsp_valid SHALL remain 0 throughout a transaction.
REQ-029 An unbounded mem_gnt or mem_rvalid stall SHALL hold state indefinitely, with no timeout.

Reset
REQ-030 While rst_n=0 at a clock edge, the FSM SHALL enter IDLE and starve_cnt SHALL clear to 0.
REQ-031 While rst_n=0 at a clock edge, all outputs (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rsp_valid, ls_rsp_valid, if_rdata, ls_rdata, busy) SHALL clear to 0.
REQ-032 While rst_n=0, the ready outputs SHALL be 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction, generate no response, and ignore any later mem_rvalid.

Verification
REQ-034 Single IF read: if_addr=0x0000_0010 accepted at cycle 0, mem_gnt immediate, mem_rdata=0x0051_0513 at cycle 2 -> if_rsp_valid=1 with if_rdata=0x0051_0513 at cycle 3, busy low again.
REQ-035 Simultaneous requests: IF 0x20 and LSU load 0x100 both valid in IDLE -> LSU accepted first, and IF accepted in the cycle ls_rsp_valid pulses.
REQ-036 Starvation: LSU valid continuously, IF valid continuously -> exactly 4 LSU grants, then 1 IF grant, then LSU resumes.
REQ-037 LSU write: addr 0x200, wdata 0xDEAD_BEEF, wstrb 4'b0011, mem_gnt delayed 3 cycles -> mem fields stable for all 4 ISSUE cycles, and ls_rsp_valid=1 with ls_rdata=0.
REQ-038 Reset in WAIT: rst_n=0 for one cycle, then mem_rvalid=1 -> no rsp_valid pulse, FSM in IDLE, both readies follow arbitration.
REQ-039 Spurious mem_rvalid=1 in IDLE -> no rsp_valid pulse and no state change.

Source files
------------

// File: rtl/mu_mem_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter onto one memory port.
// One transaction outstanding; LSU has priority with a bounded fetch-starvation window.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module mu_mem_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = `CPU_WIDTH,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic                ls_we,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wstrb,
   output logic                ls_rsp_valid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    starve_q, starve_d;
   logic                ls_own_q, ls_own_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                mem_req_q, mem_req_d;
   logic                busy_q, busy_d;
   logic                if_rsp_valid_q, if_rsp_valid_d;
   logic                ls_rsp_valid_q, ls_rsp_valid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

   logic                starve_full;
   logic                if_win;
   logic                ls_win;
   logic                if_acc;
   logic                ls_acc;

   // Arbitration: LSU first unless fetch has waited out the starvation window.
   always_comb begin
      starve_full  = (starve_q == CNT_W'(STARVE_MAX));
      if_win       = if_req_valid && (!ls_req_valid || starve_full);
      ls_win       = ls_req_valid && !if_win;
      if_req_ready = rst_n && (state_q == ST_IDLE) && if_win;
      ls_req_ready = rst_n && (state_q == ST_IDLE) && ls_win;
      if_acc       = if_req_valid && if_req_ready;
      ls_acc       = ls_req_valid && ls_req_ready;
   end

   always_comb begin
      state_d        = state_q;
      starve_d       = starve_q;
      ls_own_d       = ls_own_q;
      addr_d         = addr_q;
      we_d           = we_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      if_rdata_d     = if_rdata_q;
      ls_rdata_d     = ls_rdata_q;
      if_rsp_valid_d = 1'b0;
      ls_rsp_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (if_acc) begin
               ls_own_d = 1'b0;
               addr_d   = if_addr;
               we_d     = 1'b0;
               wdata_d  = '0;
               wstrb_d  = '0;
               starve_d = '0;
               state_d  = ST_ISSUE;
            end else if (ls_acc) begin
               ls_own_d = 1'b1;
               addr_d   = ls_addr;
               we_d     = ls_we;
               wdata_d  = ls_wdata;
               wstrb_d  = ls_wstrb;
               if (if_req_valid && !starve_full) begin
                  starve_d = starve_q + CNT_W'(1);
               end
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (mem_gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               state_d = ST_IDLE;
               if (ls_own_q) begin
                  ls_rsp_valid_d = 1'b1;
                  ls_rdata_d     = we_q ? '0 : mem_rdata;
               end else begin
                  if_rsp_valid_d = 1'b1;
                  if_rdata_d     = mem_rdata;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      mem_req_d = (state_d == ST_ISSUE);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         starve_q       <= '0;
         ls_own_q       <= 1'b0;
         addr_q         <= '0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         mem_req_q      <= 1'b0;
         busy_q         <= 1'b0;
         if_rsp_valid_q <= 1'b0;
         ls_rsp_valid_q <= 1'b0;
         if_rdata_q     <= '0;
         ls_rdata_q     <= '0;
      end else begin
         state_q        <= state_d;
         starve_q       <= starve_d;
         ls_own_q       <= ls_own_d;
         addr_q         <= addr_d;
         we_q           <= we_d;
         wdata_q        <= wdata_d;
         wstrb_q        <= wstrb_d;
         mem_req_q      <= mem_req_d;
         busy_q         <= busy_d;
         if_rsp_valid_q <= if_rsp_valid_d;
         ls_rsp_valid_q <= ls_rsp_valid_d;
         if_rdata_q     <= if_rdata_d;
         ls_rdata_q     <= ls_rdata_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_addr     = addr_q;
   assign mem_we       = we_q;
   assign mem_wdata    = wdata_q;
   assign mem_wstrb    = wstrb_q;
   assign busy         = busy_q;
   assign if_rsp_valid = if_rsp_valid_q;
   assign ls_rsp_valid = ls_rsp_valid_q;
   assign if_rdata     = if_rdata_q;
   assign ls_rdata     = ls_rdata_q;

endmodule

// File: tb/tb_mu_mem_arbiter.sv
// Directed bench for mu_mem_arbiter: reset, single fetch, contention, starvation,
// delayed-grant write, reset mid-transaction and stray memory handshakes.
module tb_mu_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_valid, if_req_ready, if_rsp_valid;
   logic [31:0] if_addr, if_rdata;
   logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
   logic [31:0] ls_addr, ls_wdata, ls_rdata;
   logic [3:0]  ls_wstrb;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int errors = 0;
   int checks = 0;

   mu_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
      .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
      .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic exp_ls [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      rst_n = 1'b0;
      if_req_valid = 1'b1; if_addr = 32'h0;
      ls_req_valid = 1'b1; ls_addr = 32'h0; ls_we = 1'b0; ls_wdata = 32'h0; ls_wstrb = 4'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

      // Reset state
      tick(); tick();
      check("rst_if_ready", if_req_ready, 1'b0);
      check("rst_ls_ready", ls_req_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_if_rsp", if_rsp_valid, 1'b0);
      check("rst_ls_rsp", ls_rsp_valid, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      // Single fetch read
      if_req_valid = 1'b1; if_addr = 32'h0000_0010; #1;
      check("f_if_ready", if_req_ready, 1'b1);
      check("f_ls_ready", ls_req_ready, 1'b0);
      tick();
      if_req_valid = 1'b0;
      check("f_mem_req", mem_req, 1'b1);
      check("f_mem_addr", mem_addr, 32'h10);
      check("f_mem_we", mem_we, 1'b0);
      check("f_mem_wstrb", mem_wstrb, 4'h0);
      check("f_busy", busy, 1'b1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check("f_wait_req", mem_req, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = 32'h0051_0513;
      tick();
      mem_rvalid = 1'b0;
      check("f_rsp", if_rsp_valid, 1'b1);
      check("f_rdata", if_rdata, 32'h0051_0513);
      check("f_ls_rsp", ls_rsp_valid, 1'b0);
      check("f_busy_low", busy, 1'b0);
      tick();
      check("f_rsp_pulse", if_rsp_valid, 1'b0);

      // Simultaneous requests: LSU first, fetch accepted on the LSU response cycle
      if_req_valid = 1'b1; if_addr = 32'h20;
      ls_req_valid = 1'b1; ls_addr = 32'h100; ls_we = 1'b0; #1;
      check("s_ls_ready", ls_req_ready, 1'b1);
      check("s_if_ready", if_req_ready, 1'b0);
      tick();
      ls_req_valid = 1'b0; #1;
      check("s_issue_if_ready", if_req_ready, 1'b0);
      check("s_issue_addr", mem_addr, 32'h100);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
      check("s_wait_if_ready", if_req_ready, 1'b0);
      tick();
      mem_rvalid = 1'b0;
      check("s_ls_rsp", ls_rsp_valid, 1'b1);
      check("s_ls_rdata", ls_rdata, 32'hCAFE_0001);
      check("s_if_rsp_none", if_rsp_valid, 1'b0);
      check("s_if_ready_rsp", if_req_ready, 1'b1);
      tick();
      if_req_valid = 1'b0;
      check("s_if_issue_addr", mem_addr, 32'h20);
      check("s_ls_rsp_pulse", ls_rsp_valid, 1'b0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
      tick();
      mem_rvalid = 1'b0;
      check("s_if_rsp", if_rsp_valid, 1'b1);
      check("s_if_rdata", if_rdata, 32'h11);
      check("s_ls_rsp_none", ls_rsp_valid, 1'b0);

      // Starvation: four LSU grants, one fetch grant, LSU resumes
      if_req_valid = 1'b1; if_addr = 32'h30;
      ls_req_valid = 1'b1; ls_addr = 32'h140; #1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("st_ls_ready_%0d", i), ls_req_ready, exp_ls[i]);
         check($sformatf("st_if_ready_%0d", i), if_req_ready, !exp_ls[i]);
         tick();
         check($sformatf("st_addr_%0d", i), mem_addr, exp_ls[i] ? 32'h140 : 32'h30);
         mem_gnt = 1'b1;
         tick();
         mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h100 + 32'(i);
         tick();
         mem_rvalid = 1'b0;
         check($sformatf("st_rsp_%0d", i), exp_ls[i] ? ls_rsp_valid : if_rsp_valid, 1'b1);
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      tick();

      // LSU write with grant held off for three cycles
      ls_req_valid = 1'b1; ls_addr = 32'h200; ls_we = 1'b1;
      ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'b0011; #1;
      check("w_ls_ready", ls_req_ready, 1'b1);
      tick();
      ls_req_valid = 1'b0; ls_we = 1'b0; ls_wdata = 32'h0; ls_wstrb = 4'h0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("w_req_%0d", k), mem_req, 1'b1);
         check($sformatf("w_addr_%0d", k), mem_addr, 32'h200);
         check($sformatf("w_we_%0d", k), mem_we, 1'b1);
         check($sformatf("w_wdata_%0d", k), mem_wdata, 32'hDEAD_BEEF);
         check($sformatf("w_wstrb_%0d", k), mem_wstrb, 4'b0011);
         mem_gnt = (k == 3);
         tick();
      end
      mem_gnt = 1'b0;
      check("w_wait_req", mem_req, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_rvalid = 1'b0;
      check("w_rsp", ls_rsp_valid, 1'b1);
      check("w_rdata_zero", ls_rdata, 32'h0);
      check("w_if_rsp_none", if_rsp_valid, 1'b0);
      tick();

      // Reset while waiting for completion
      ls_req_valid = 1'b1; ls_addr = 32'h300; #1;
      tick();
      ls_req_valid = 1'b0; mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check("r_busy_wait", busy, 1'b1);
      rst_n = 1'b0; if_req_valid = 1'b1; #1;
      check("r_rst_if_ready", if_req_ready, 1'b0);
      tick();
      rst_n = 1'b1; if_req_valid = 1'b0;
      check("r_busy", busy, 1'b0);
      check("r_mem_req", mem_req, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
      if_req_valid = 1'b1; ls_req_valid = 1'b1; #1;
      check("r_ls_ready", ls_req_ready, 1'b1);
      check("r_if_ready", if_req_ready, 1'b0);
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      tick();
      mem_rvalid = 1'b0;
      check("r_ls_rsp", ls_rsp_valid, 1'b0);
      check("r_if_rsp", if_rsp_valid, 1'b0);
      check("r_busy_after", busy, 1'b0);

      // Stray completion and grant while idle
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_rvalid = 1'b0; mem_gnt = 1'b1;
      check("x_ls_rsp", ls_rsp_valid, 1'b0);
      check("x_if_rsp", if_rsp_valid, 1'b0);
      check("x_busy", busy, 1'b0);
      tick();
      mem_gnt = 1'b0;
      check("x_gnt_busy", busy, 1'b0);
      check("x_gnt_req", mem_req, 1'b0);
      ls_req_valid = 1'b1; #1;
      check("x_ls_ready", ls_req_ready, 1'b1);
      ls_req_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
